// File: rtl/roc_decoder.sv
// roc_decoder: receiving end of the 10-bit AER rank-order-coded link.
// Handshakes each address event, detects the double-marker frame start and rebuilds intensity from arrival rank.
module roc_decoder #(
   parameter int         IMAGE_SIZE      = 256,
   parameter int         IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
   parameter int         PIXEL_MAX_VALUE = 255,
   parameter int         PIXEL_BITS      = 8,
   parameter logic [9:0] MARKER          = 10'h1FF
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [9:0]              AERIN_ADDR,
   input  logic                    AERIN_REQ,
   output logic                    AERIN_ACK,
   input  logic                    FRAME_END,
   output logic [PIXEL_BITS-1:0]   IMAGE_OUT [0:IMAGE_SIZE-1],
   output logic [IMAGE_SIZE_BITS:0] RANK_CNT,
   output logic                    NEW_FRAME,
   output logic                    IMAGE_VALID,
   output logic                    ERR_EVENT
);

   localparam int                RANK_W    = IMAGE_SIZE_BITS + 1;
   localparam logic [RANK_W-1:0] RANK_FULL = RANK_W'(IMAGE_SIZE);
   localparam logic [RANK_W-1:0] RANK_ONE  = RANK_W'(1);

   typedef enum logic [1:0] {
      WAIT_REQ = 2'd0,
      ACK_HI   = 2'd1,
      COMMIT   = 2'd2
   } state_t;

   state_t                      state_q, state_d;
   logic [9:0]                  addr_q, addr_d;
   logic                        ack_q, ack_d;
   logic [RANK_W-1:0]           rank_q, rank_d;
   logic                        new_frame_q, new_frame_d;
   logic                        image_valid_q, image_valid_d;
   logic                        err_q, err_d;
   logic                        armed_q, armed_d;
   logic [1:0]                  marker_cnt_q, marker_cnt_d;
   logic [IMAGE_SIZE-1:0]       valid_q, valid_d;
   logic [PIXEL_BITS-1:0]       image_q [0:IMAGE_SIZE-1];
   logic [PIXEL_BITS-1:0]       image_d [0:IMAGE_SIZE-1];

   logic                        is_marker_s;
   logic                        is_data_s;
   logic [IMAGE_SIZE_BITS-1:0]  pix_s;
   logic [PIXEL_BITS-1:0]       inten_s;

   assign is_marker_s = (addr_q == MARKER);
   assign is_data_s   = (addr_q[9:8] == 2'b00) && ({24'd0, addr_q[7:0]} < 32'(IMAGE_SIZE))
                        && armed_q && !image_valid_q;
   assign pix_s       = addr_q[IMAGE_SIZE_BITS-1:0];
   // Ranks beyond the brightest-to-darkest range collapse to zero intensity.
   assign inten_s     = (32'(rank_q) > 32'(PIXEL_MAX_VALUE)) ? '0
                        : PIXEL_BITS'(32'(PIXEL_MAX_VALUE) - 32'(rank_q));

   // Handshake FSM plus commit-time classification and frame bookkeeping.
   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      ack_d         = ack_q;
      rank_d        = rank_q;
      new_frame_d   = 1'b0;
      err_d         = 1'b0;
      image_valid_d = image_valid_q;
      armed_d       = armed_q;
      marker_cnt_d  = marker_cnt_q;
      valid_d       = valid_q;
      image_d       = image_q;

      case (state_q)
         WAIT_REQ: begin
            if (AERIN_REQ) begin
               addr_d  = AERIN_ADDR;
               ack_d   = 1'b1;
               state_d = ACK_HI;
            end else begin
               ack_d   = 1'b0;
            end
         end
         ACK_HI: begin
            if (AERIN_REQ) begin
               ack_d   = 1'b1;
            end else begin
               ack_d   = 1'b0;
               state_d = COMMIT;
            end
         end
         COMMIT: begin
            ack_d   = 1'b0;
            state_d = WAIT_REQ;
            if (is_marker_s) begin
               // The counter never rests at 2: the second marker arms and restarts the count.
               if (marker_cnt_q >= 2'd1) begin
                  valid_d       = '0;
                  image_d       = '{default: '0};
                  rank_d        = '0;
                  armed_d       = 1'b1;
                  image_valid_d = 1'b0;
                  new_frame_d   = 1'b1;
                  marker_cnt_d  = 2'd0;
               end else begin
                  marker_cnt_d  = marker_cnt_q + 2'd1;
               end
            end else if (is_data_s && !valid_q[pix_s]) begin
               valid_d[pix_s] = 1'b1;
               image_d[pix_s] = inten_s;
               rank_d         = rank_q + RANK_ONE;
               marker_cnt_d   = 2'd0;
               if (rank_d == RANK_FULL) begin
                  image_valid_d = 1'b1;
                  armed_d       = 1'b0;
               end else begin
                  armed_d       = armed_q;
               end
            end else begin
               err_d        = 1'b1;
               marker_cnt_d = 2'd0;
            end
         end
         default: begin
            ack_d   = 1'b0;
            state_d = WAIT_REQ;
         end
      endcase

      // A forced end sees the result of any same-cycle commit.
      if (FRAME_END && armed_d) begin
         image_valid_d = 1'b1;
         armed_d       = 1'b0;
      end else begin
         image_valid_d = image_valid_d;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q       <= WAIT_REQ;
         addr_q        <= 10'd0;
         ack_q         <= 1'b0;
         rank_q        <= '0;
         new_frame_q   <= 1'b0;
         image_valid_q <= 1'b0;
         err_q         <= 1'b0;
         armed_q       <= 1'b0;
         marker_cnt_q  <= 2'd0;
         valid_q       <= '0;
         image_q       <= '{default: '0};
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         ack_q         <= ack_d;
         rank_q        <= rank_d;
         new_frame_q   <= new_frame_d;
         image_valid_q <= image_valid_d;
         err_q         <= err_d;
         armed_q       <= armed_d;
         marker_cnt_q  <= marker_cnt_d;
         valid_q       <= valid_d;
         image_q       <= image_d;
      end
   end

   assign AERIN_ACK   = ack_q;
   assign IMAGE_OUT   = image_q;
   assign RANK_CNT    = rank_q;
   assign NEW_FRAME   = new_frame_q;
   assign IMAGE_VALID = image_valid_q;
   assign ERR_EVENT   = err_q;

endmodule

// File: tb/tb_roc_decoder.sv
// Directed bench for roc_decoder: handshake timing, arming, rank-to-intensity mapping,
// completion, error pulses and reset during a handshake.
`timescale 1ns/1ps
module tb_roc_decoder;

   logic       CLK = 1'b0;
   logic       RST;
   logic [9:0] AERIN_ADDR;
   logic       AERIN_REQ;
   logic       AERIN_ACK;
   logic       FRAME_END;
   logic [7:0] IMAGE_OUT [0:255];
   logic [8:0] RANK_CNT;
   logic       NEW_FRAME;
   logic       IMAGE_VALID;
   logic       ERR_EVENT;

   int         vec_cnt  = 0;
   int         miss_cnt = 0;
   logic       ev_err;
   logic       ev_nf;
   logic [7:0] exp_img [0:255];

   roc_decoder dut (
      .CLK        (CLK),
      .RST        (RST),
      .AERIN_ADDR (AERIN_ADDR),
      .AERIN_REQ  (AERIN_REQ),
      .AERIN_ACK  (AERIN_ACK),
      .FRAME_END  (FRAME_END),
      .IMAGE_OUT  (IMAGE_OUT),
      .RANK_CNT   (RANK_CNT),
      .NEW_FRAME  (NEW_FRAME),
      .IMAGE_VALID(IMAGE_VALID),
      .ERR_EVENT  (ERR_EVENT)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_exp();
      for (int i = 0; i < 256; i++) exp_img[i] = 8'd0;
   endtask

   function automatic int count_diff();
      int d = 0;
      for (int i = 0; i < 256; i++) if (IMAGE_OUT[i] !== exp_img[i]) d++;
      return d;
   endfunction

   task automatic do_reset();
      RST = 1'b1; AERIN_REQ = 1'b0; FRAME_END = 1'b0; AERIN_ADDR = 10'd0;
      tick(); tick();
      RST = 1'b0;
   endtask

   // Full 4-phase event; checks ACK latency and captures the commit-cycle pulses.
   task automatic send_event(input logic [9:0] a);
      int n;
      AERIN_ADDR = a; AERIN_REQ = 1'b1;
      n = 0;
      do begin tick(); n++; end while (AERIN_ACK !== 1'b1 && n < 8);
      vec_cnt++;
      if (n != 1 || AERIN_ACK !== 1'b1) begin
         miss_cnt++;
         $display("FAIL ack_rise addr=%h: ack=%b after %0d cycles, required 1 after 1 cycle", a, AERIN_ACK, n);
      end
      AERIN_REQ = 1'b0;
      n = 0;
      do begin tick(); n++; end while (AERIN_ACK !== 1'b0 && n < 8);
      vec_cnt++;
      if (n != 1 || AERIN_ACK !== 1'b0) begin
         miss_cnt++;
         $display("FAIL ack_fall addr=%h: ack=%b after %0d cycles, required 0 after 1 cycle", a, AERIN_ACK, n);
      end
      tick();
      ev_err = ERR_EVENT;
      ev_nf  = NEW_FRAME;
   endtask

   task automatic arm();
      send_event(10'h1FF);
      send_event(10'h1FF);
   endtask

   task automatic test_reset();
      do_reset();
      vec_cnt++;
      if ({AERIN_ACK, NEW_FRAME, IMAGE_VALID, ERR_EVENT, RANK_CNT} !== 13'd0) begin
         miss_cnt++;
         $display("FAIL reset_outputs: got %b, required 0", {AERIN_ACK, NEW_FRAME, IMAGE_VALID, ERR_EVENT, RANK_CNT});
      end
      clear_exp();
      vec_cnt++;
      if (count_diff() != 0) begin
         miss_cnt++; $display("FAIL reset_image: %0d pixels nonzero, required 0", count_diff());
      end
   endtask

   task automatic test_arm();
      send_event(10'h1FF);
      vec_cnt++;
      if ({ev_nf, ev_err} !== 2'b00) begin
         miss_cnt++; $display("FAIL marker1 {nf,err}: got %b, required 00", {ev_nf, ev_err});
      end
      send_event(10'h1FF);
      vec_cnt++;
      if ({ev_nf, ev_err} !== 2'b10) begin
         miss_cnt++; $display("FAIL marker2 {nf,err}: got %b, required 10", {ev_nf, ev_err});
      end
      tick();
      vec_cnt++;
      if (NEW_FRAME !== 1'b0) begin
         miss_cnt++; $display("FAIL new_frame_width: got %b, required 0", NEW_FRAME);
      end
      vec_cnt++;
      if ({IMAGE_VALID, RANK_CNT} !== 10'd0) begin
         miss_cnt++; $display("FAIL armed_state {valid,rank}: got %b, required 0", {IMAGE_VALID, RANK_CNT});
      end
   endtask

   task automatic test_three_pixels();
      arm(); clear_exp();
      send_event(10'd5); send_event(10'd3); send_event(10'd200);
      exp_img[5] = 8'd255; exp_img[3] = 8'd254; exp_img[200] = 8'd253;
      vec_cnt++;
      if (count_diff() != 0) begin
         miss_cnt++;
         $display("FAIL three_image: [5]=%0d [3]=%0d [200]=%0d diffs=%0d, required 255 254 253 diffs=0",
                  IMAGE_OUT[5], IMAGE_OUT[3], IMAGE_OUT[200], count_diff());
      end
      vec_cnt++;
      if ({IMAGE_VALID, RANK_CNT} !== {1'b0, 9'd3}) begin
         miss_cnt++; $display("FAIL three_rank: valid=%b rank=%0d, required 0 3", IMAGE_VALID, RANK_CNT);
      end
   endtask

   task automatic test_full_frame();
      arm(); clear_exp();
      for (int k = 0; k < 256; k++) begin
         send_event(10'(255 - k));
         exp_img[255 - k] = 8'(255 - k);
         if (k == 254) begin
            vec_cnt++;
            if (IMAGE_VALID !== 1'b0) begin
               miss_cnt++; $display("FAIL full_early_valid: got %b, required 0", IMAGE_VALID);
            end
         end
      end
      vec_cnt++;
      if ({IMAGE_VALID, RANK_CNT} !== {1'b1, 9'd256}) begin
         miss_cnt++; $display("FAIL full_complete: valid=%b rank=%0d, required 1 256", IMAGE_VALID, RANK_CNT);
      end
      vec_cnt++;
      if (count_diff() != 0) begin
         miss_cnt++; $display("FAIL full_image: %0d pixels differ from identity, required 0", count_diff());
      end
      send_event(10'd10);
      vec_cnt++;
      if ({ev_err, RANK_CNT, IMAGE_OUT[10]} !== {1'b1, 9'd256, 8'd10}) begin
         miss_cnt++;
         $display("FAIL full_extra: err=%b rank=%0d px10=%0d, required 1 256 10", ev_err, RANK_CNT, IMAGE_OUT[10]);
      end
   endtask

   task automatic test_duplicate();
      int errs;
      logic [9:0] seq [4];
      seq = '{10'd7, 10'd7, 10'h2AB, 10'd9};
      arm(); clear_exp();
      errs = 0;
      for (int i = 0; i < 4; i++) begin
         send_event(seq[i]);
         if (ev_err === 1'b1) errs++;
      end
      exp_img[7] = 8'd255; exp_img[9] = 8'd254;
      vec_cnt++;
      if (errs != 2) begin
         miss_cnt++; $display("FAIL dup_errors: got %0d pulses, required 2", errs);
      end
      vec_cnt++;
      if (count_diff() != 0 || RANK_CNT !== 9'd2) begin
         miss_cnt++;
         $display("FAIL dup_image: [7]=%0d [9]=%0d rank=%0d, required 255 254 2", IMAGE_OUT[7], IMAGE_OUT[9], RANK_CNT);
      end
   endtask

   task automatic test_unarmed();
      do_reset(); clear_exp();
      FRAME_END = 1'b1; tick(); FRAME_END = 1'b0; tick();
      vec_cnt++;
      if (IMAGE_VALID !== 1'b0) begin
         miss_cnt++; $display("FAIL unarmed_frame_end: valid=%b, required 0", IMAGE_VALID);
      end
      send_event(10'd4);
      vec_cnt++;
      if (ev_err !== 1'b1) begin
         miss_cnt++; $display("FAIL unarmed_data: err=%b, required 1", ev_err);
      end
      send_event(10'h1FF);
      send_event(10'd4);
      vec_cnt++;
      if (ev_err !== 1'b1) begin
         miss_cnt++; $display("FAIL lone_marker_data: err=%b, required 1", ev_err);
      end
      send_event(10'h1FF);
      send_event(10'h1FF);
      vec_cnt++;
      if (ev_nf !== 1'b1) begin
         miss_cnt++; $display("FAIL rearm_new_frame: nf=%b, required 1", ev_nf);
      end
      send_event(10'd4);
      exp_img[4] = 8'd255;
      vec_cnt++;
      if (ev_err !== 1'b0 || count_diff() != 0 || RANK_CNT !== 9'd1) begin
         miss_cnt++;
         $display("FAIL armed_data: err=%b px4=%0d rank=%0d, required 0 255 1", ev_err, IMAGE_OUT[4], RANK_CNT);
      end
   endtask

   task automatic test_frame_end_reset();
      arm(); clear_exp();
      send_event(10'd1); send_event(10'd2);
      FRAME_END = 1'b1; tick(); FRAME_END = 1'b0;
      vec_cnt++;
      if ({IMAGE_VALID, RANK_CNT} !== {1'b1, 9'd2}) begin
         miss_cnt++; $display("FAIL frame_end: valid=%b rank=%0d, required 1 2", IMAGE_VALID, RANK_CNT);
      end
      AERIN_ADDR = 10'd6; AERIN_REQ = 1'b1;
      tick();
      vec_cnt++;
      if (AERIN_ACK !== 1'b1) begin
         miss_cnt++; $display("FAIL pre_reset_ack: got %b, required 1", AERIN_ACK);
      end
      RST = 1'b1;
      tick();
      vec_cnt++;
      if ({AERIN_ACK, NEW_FRAME, IMAGE_VALID, ERR_EVENT, RANK_CNT} !== 13'd0 || count_diff() != 0) begin
         miss_cnt++;
         $display("FAIL mid_reset: outs=%b image_diffs=%0d, required 0 0",
                  {AERIN_ACK, NEW_FRAME, IMAGE_VALID, ERR_EVENT, RANK_CNT}, count_diff());
      end
      RST = 1'b0; AERIN_REQ = 1'b0;
      tick(); tick(); tick(); tick();
      vec_cnt++;
      if ({AERIN_ACK, RANK_CNT} !== 10'd0 || count_diff() != 0) begin
         miss_cnt++;
         $display("FAIL post_reset_discard: ack=%b rank=%0d diffs=%0d, required 0 0 0", AERIN_ACK, RANK_CNT, count_diff());
      end
   endtask

   initial begin
      test_reset();
      test_arm();
      test_three_pixels();
      test_full_frame();
      test_duplicate();
      test_unarmed();
      test_frame_end_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
